// File: rtl/ssd_digit_loader.sv
// ssd_digit_loader: synchronises and debounces four buttons and a hex switch nibble, and
// loads the nibble into digit i on each clean press of button i. Macro SSD_HOLD_INC_EN adds hold-to-increment.
module ssd_digit_loader #(
    parameter int DB_CNT_MAX    = 250000,
    parameter int CNT_W         = 18,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_i,
    input  logic [3:0] sw_i,
    output logic [3:0] digit0_o,
    output logic [3:0] digit1_o,
    output logic [3:0] digit2_o,
    output logic [3:0] digit3_o,
    output logic [3:0] digit_valid_o,
    output logic [3:0] load_pulse_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT_MAX);

    if (DB_CNT_MAX < 2 || (DB_CNT_MAX >> CNT_W) != 0 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("ssd_digit_loader: DB_CNT_MAX must be >= 2 and fit CNT_W; REPEAT_CYCLES must be >= 2");
    end

    logic [3:0]       btn_meta_q, btn_s_q;
    logic [3:0]       sw_meta_q, sw_s_q;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       digit_q [4];
    logic [3:0]       digit_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       pulse_q, pulse_d;

`ifdef SSD_HOLD_INC_EN
    // Sized from the period itself so a long repeat does not force a wide debounce counter.
    localparam int              REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_q [4];
    logic [REP_W-1:0] rep_d [4];
`endif

    always_comb begin
        // NOTE: every next-state value starts from its register, so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        valid_d = valid_q;
        pulse_d = '0;
`ifdef SSD_HOLD_INC_EN
        rep_d   = rep_q;
`endif
        for (int i = 0; i < 4; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (btn_s_q[i]) begin
                        state_d[i] = PRESS;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                PRESS: begin
                    if (!btn_s_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        digit_d[i] = sw_s_q;
                        valid_d[i] = 1'b1;
                        pulse_d[i] = 1'b1;
`ifdef SSD_HOLD_INC_EN
                        rep_d[i]   = '0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s_q[i]) begin
                        state_d[i] = RELEASE;
                        cnt_d[i]   = CNT_W'(1);
`ifdef SSD_HOLD_INC_EN
                    end else if (rep_q[i] == REP_LAST) begin
                        rep_d[i]   = '0;
                        digit_d[i] = digit_q[i] + 4'd1;
                        pulse_d[i] = 1'b1;
                    end else begin
                        rep_d[i] = rep_q[i] + 1'b1;
`endif
                    end
                end
                default: begin // RELEASE
                    if (btn_s_q[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
`ifdef SSD_HOLD_INC_EN
                        rep_d[i]   = '0;
`endif
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            btn_meta_q <= '0;
            btn_s_q    <= '0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            state_q    <= '{default: IDLE};
            cnt_q      <= '{default: '0};
            digit_q    <= '{default: '0};
            valid_q    <= '0;
            pulse_q    <= '0;
`ifdef SSD_HOLD_INC_EN
            rep_q      <= '{default: '0};
`endif
        end else begin
            btn_meta_q <= btn_i;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= sw_i;
            sw_s_q     <= sw_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            pulse_q    <= pulse_d;
`ifdef SSD_HOLD_INC_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign digit0_o      = digit_q[0];
    assign digit1_o      = digit_q[1];
    assign digit2_o      = digit_q[2];
    assign digit3_o      = digit_q[3];
    assign digit_valid_o = valid_q;
    assign load_pulse_o  = pulse_q;

endmodule
